// File: rtl/ram_arb_pkg.sv
// Shared types and bus widths for the two-master RAM bus arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic master_idx_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_fields_t;

endpackage

// File: rtl/ram_arb_id_fifo.sv
// Synchronous FIFO holding the master index of each outstanding read.
module ram_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_bi,
  output logic [WIDTH-1:0] rdata_bo,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full_o   = (count == FULL_CNT);
    empty_o  = (count == '0);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    rdata_bo = mem[rd_ptr];
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_bi;
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one RAM bus port between two masters with in-order read routing.
// Optional grant/stall counters are enabled by defining RAM_ARB_PERF_CNT_EN.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned RESP_FIFO_DEPTH = 4,
  parameter int unsigned PTR_W           = $clog2(RESP_FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [BE_W-1:0]   m0_be_bi,
  input  logic [DATA_W-1:0] m0_wdata_bi,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DATA_W-1:0] m0_rdata_bo,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [BE_W-1:0]   m1_be_bi,
  input  logic [DATA_W-1:0] m1_wdata_bi,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DATA_W-1:0] m1_rdata_bo,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [BE_W-1:0]   s_be_bo,
  output logic [DATA_W-1:0] s_wdata_bo,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DATA_W-1:0] s_rdata_bi,
  output logic              err_o
`ifdef RAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       m0_grant_cnt_o,
  output logic [31:0]       m1_grant_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  req_fields_t m0_f, m1_f, s_f;
  master_idx_t last_grant, grant, head_id;
  logic        fifo_full, fifo_empty;
  logic        elig0, elig1, xfer, push, pop;

  always_comb begin
    m0_f  = '{we: m0_we_i, addr: m0_addr_bi, be: m0_be_bi, wdata: m0_wdata_bi};
    m1_f  = '{we: m1_we_i, addr: m1_addr_bi, be: m1_be_bi, wdata: m1_wdata_bi};
    elig0 = m0_req_i && (m0_we_i || !fifo_full);
    elig1 = m1_req_i && (m1_we_i || !fifo_full);
    // On a tie the master not served last wins; last_grant only moves on an accepted transfer.
    if (elig0 && elig1) grant = ~last_grant;
    else                grant = elig1;
    s_req_o = (elig0 || elig1) && rst_n_i;
    s_f     = s_req_o ? (grant ? m1_f : m0_f) : '0;
    xfer    = s_req_o && s_ack_i;
    push    = xfer && !s_f.we;
    pop     = s_resp_i && !fifo_empty && rst_n_i;
  end

  assign s_we_o      = s_f.we;
  assign s_addr_bo   = s_f.addr;
  assign s_be_bo     = s_f.be;
  assign s_wdata_bo  = s_f.wdata;
  assign m0_ack_o    = xfer && !grant;
  assign m1_ack_o    = xfer && grant;
  assign m0_resp_o   = pop && !head_id;
  assign m1_resp_o   = pop && head_id;
  assign m0_rdata_bo = s_rdata_bi;
  assign m1_rdata_bo = s_rdata_bi;

  ram_arb_id_fifo #(
    .DEPTH (RESP_FIFO_DEPTH),
    .WIDTH (1),
    .PTR_W (PTR_W)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .push_i   (push),
    .pop_i    (pop),
    .wdata_bi (grant),
    .rdata_bo (head_id),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_grant <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (xfer) last_grant <= grant;
      if (s_resp_i && fifo_empty) err_o <= 1'b1;
    end
  end

`ifdef RAM_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      m0_grant_cnt_o <= '0;
      m1_grant_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (m0_ack_o)              m0_grant_cnt_o <= m0_grant_cnt_o + 32'd1;
      if (m1_ack_o)              m1_grant_cnt_o <= m1_grant_cnt_o + 32'd1;
      if (s_req_o && !s_ack_i)   stall_cnt_o    <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_ram_bus_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_resp, m1_ack, m1_resp;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack, s_resp, err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
`ifdef RAM_ARB_PERF_CNT_EN
  logic [31:0] m0_gcnt, m1_gcnt, stall_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.RESP_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
    .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
    .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata), .err_o(err)
`ifdef RAM_ARB_PERF_CNT_EN
    , .m0_grant_cnt_o(m0_gcnt), .m1_grant_cnt_o(m1_gcnt), .stall_cnt_o(stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
    s_ack = 0; s_resp = 0; s_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; s_ack = 1; s_resp = 1;
    #1;
    n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_s_req: got %b want 0", s_req); end
    n_cmp++; if (m0_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", m0_ack); end
    n_cmp++; if ({m0_resp, m1_resp} !== 2'b00) begin n_err++; $display("FAIL reset_resp: got %b want 00", {m0_resp, m1_resp}); end
    tick();
    idle_inputs();
    rst_n = 1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL reset_idle_req: got %b want 0", s_req); end
  endtask

  task automatic test_alternate();
    logic [31:0] a0, a1, prev_addr;
    logic        exp_g, prev_g;
    bit          have_prev;
    a0 = 32'h100; a1 = 32'h200; prev_addr = '0; prev_g = 0; have_prev = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      m0_req = 1; m0_we = 0; m0_addr = a0; m1_req = 1; m1_we = 0; m1_addr = a1; s_ack = 1;
      s_resp = have_prev; s_rdata = have_prev ? mem_val(prev_addr) : '0;
      #1;
      exp_g = (i % 2 == 0);
      n_cmp++; if ({m1_ack, m0_ack} !== {exp_g, !exp_g}) begin
        n_err++; $display("FAIL alt_ack[%0d]: got m1/m0=%b%b want %b%b", i, m1_ack, m0_ack, exp_g, !exp_g);
      end
      n_cmp++; if (s_addr !== (exp_g ? a1 : a0)) begin
        n_err++; $display("FAIL alt_addr[%0d]: got %h want %h", i, s_addr, exp_g ? a1 : a0);
      end
      if (have_prev) begin
        n_cmp++; if ({m1_resp, m0_resp} !== {prev_g, !prev_g}) begin
          n_err++; $display("FAIL alt_resp[%0d]: got m1/m0=%b%b want %b%b", i, m1_resp, m0_resp, prev_g, !prev_g);
        end
        n_cmp++; if ((prev_g ? m1_rdata : m0_rdata) !== mem_val(prev_addr)) begin
          n_err++; $display("FAIL alt_rdata[%0d]: got %h want %h", i, prev_g ? m1_rdata : m0_rdata, mem_val(prev_addr));
        end
      end
      prev_g = exp_g; prev_addr = exp_g ? a1 : a0; have_prev = 1;
      if (exp_g) a1 += 32'd4; else a0 += 32'd4;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hCAFE; s_ack = 1;
    #1;
    n_cmp++; if (m1_ack !== 1'b1) begin n_err++; $display("FAIL stall_prime: got %b want 1", m1_ack); end
    tick();
    m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 32'h300; s_ack = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin m1_req = 1; m1_we = 0; m1_addr = 32'h400; end
      #1;
      n_cmp++; if (s_addr !== 32'h300 || s_req !== 1'b1) begin
        n_err++; $display("FAIL stall_grant[%0d]: got req=%b addr=%h want 1 00000300", k, s_req, s_addr);
      end
      n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin
        n_err++; $display("FAIL stall_ack[%0d]: got %b%b want 00", k, m0_ack, m1_ack);
      end
      tick();
    end
    s_ack = 1;
    #1;
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL stall_first_ack: got m0/m1=%b%b want 10", m0_ack, m1_ack); end
    tick();
    m0_addr = 32'h304;
    #1;
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b01) begin n_err++; $display("FAIL stall_rr_next: got m0/m1=%b%b want 01", m0_ack, m1_ack); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    s_ack = 1; m0_req = 1; m0_we = 0;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h500 + 32'(4 * i);
      #1;
      n_cmp++; if (m0_ack !== 1'b1) begin n_err++; $display("FAIL full_fill[%0d]: got %b want 1", i, m0_ack); end
      tick();
    end
    m0_addr = 32'h510; m1_req = 1; m1_we = 1; m1_addr = 32'h600; m1_wdata = 32'h1234_5678; m1_be = 4'hF;
    #1;
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b01) begin n_err++; $display("FAIL full_write_pass: got m0/m1=%b%b want 01", m0_ack, m1_ack); end
    n_cmp++; if ({s_we, s_wdata} !== {1'b1, 32'h1234_5678}) begin n_err++; $display("FAIL full_write_fields: got %b %h want 1 12345678", s_we, s_wdata); end
    tick();
    m1_req = 0; m1_we = 0;
    #1;
    n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL full_read_blocked: got %b want 0", s_req); end
    tick();
    s_resp = 1; s_rdata = mem_val(32'h500);
    #1;
    n_cmp++; if ({m0_ack, m0_resp} !== 2'b01) begin n_err++; $display("FAIL full_pop_cycle: got ack/resp=%b%b want 01", m0_ack, m0_resp); end
    n_cmp++; if (m0_rdata !== mem_val(32'h500)) begin n_err++; $display("FAIL full_rdata: got %h want %h", m0_rdata, mem_val(32'h500)); end
    tick();
    s_resp = 0;
    #1;
    n_cmp++; if (m0_ack !== 1'b1) begin n_err++; $display("FAIL full_after_pop: got %b want 1", m0_ack); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b want 0", err); end
  endtask

  task automatic test_err();
    do_reset();
    s_resp = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({m0_resp, m1_resp} !== 2'b00) begin n_err++; $display("FAIL err_resp: got %b%b want 00", m0_resp, m1_resp); end
    tick();
    s_resp = 0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", err); end
    repeat (3) tick();
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
    do_reset();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  task automatic test_stale();
    do_reset();
    s_ack = 1; m0_req = 1; m0_we = 0; m0_addr = 32'h700; m1_req = 1; m1_we = 0; m1_addr = 32'h704;
    #1;
    n_cmp++; if (m1_ack !== 1'b1) begin n_err++; $display("FAIL stale_rd1: got %b want 1", m1_ack); end
    tick();
    m1_req = 0;
    #1;
    n_cmp++; if (m0_ack !== 1'b1) begin n_err++; $display("FAIL stale_rd2: got %b want 1", m0_ack); end
    tick();
    do_reset();
    s_resp = 1; s_rdata = mem_val(32'h704);
    #1;
    n_cmp++; if ({m0_resp, m1_resp} !== 2'b00) begin n_err++; $display("FAIL stale_resp1: got %b%b want 00", m0_resp, m1_resp); end
    tick();
    s_rdata = mem_val(32'h700);
    #1;
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL stale_err: got %b want 1", err); end
    n_cmp++; if ({m0_resp, m1_resp} !== 2'b00) begin n_err++; $display("FAIL stale_resp2: got %b%b want 00", m0_resp, m1_resp); end
    tick();
    idle_inputs();
  endtask

  // Reference: outstanding reads are a queue of {owner, data}; round-robin remembers the last served master.
  task automatic test_random(input int unsigned cycles);
    int unsigned own_q[$];
    logic [31:0] dat_q[$];
    logic        last_g, busy0, busy1, full, e0, e1, sreq, g, exp_r0, exp_r1;
    logic [68:0] exp_f;
    last_g = 0; busy0 = 0; busy1 = 0;
    do_reset();
    for (int unsigned c = 0; c < cycles; c++) begin
      if (!busy0) begin
        m0_req = 1'($urandom_range(0, 1)); m0_we = ($urandom_range(0, 3) == 0);
        m0_addr = $urandom; m0_be = 4'($urandom); m0_wdata = $urandom; busy0 = m0_req;
      end
      if (!busy1) begin
        m1_req = 1'($urandom_range(0, 1)); m1_we = ($urandom_range(0, 3) == 0);
        m1_addr = $urandom; m1_be = 4'($urandom); m1_wdata = $urandom; busy1 = m1_req;
      end
      s_ack  = ($urandom_range(0, 3) != 0);
      s_resp = (dat_q.size() > 0) && ($urandom_range(0, 2) == 0);
      s_rdata = s_resp ? dat_q[0] : $urandom;
      #1;
      full = (own_q.size() == DEPTH);
      e0 = m0_req && (m0_we || !full);
      e1 = m1_req && (m1_we || !full);
      sreq = e0 || e1;
      g = (e0 && e1) ? !last_g : e1;
      exp_f = !sreq ? '0 : (g ? {m1_we, m1_addr, m1_be, m1_wdata} : {m0_we, m0_addr, m0_be, m0_wdata});
      exp_r0 = s_resp && (own_q.size() > 0) && (own_q[0] == 0);
      exp_r1 = s_resp && (own_q.size() > 0) && (own_q[0] == 1);
      n_cmp++; if (s_req !== sreq) begin n_err++; $display("FAIL rnd_s_req[%0d]: got %b want %b", c, s_req, sreq); end
      n_cmp++; if ({s_we, s_addr, s_be, s_wdata} !== exp_f) begin
        n_err++; $display("FAIL rnd_fields[%0d]: got %h want %h", c, {s_we, s_addr, s_be, s_wdata}, exp_f);
      end
      n_cmp++; if ({m0_ack, m1_ack} !== {sreq && s_ack && !g, sreq && s_ack && g}) begin
        n_err++; $display("FAIL rnd_ack[%0d]: got m0/m1=%b%b want %b%b", c, m0_ack, m1_ack, sreq && s_ack && !g, sreq && s_ack && g);
      end
      n_cmp++; if ({m0_resp, m1_resp} !== {exp_r0, exp_r1}) begin
        n_err++; $display("FAIL rnd_resp[%0d]: got m0/m1=%b%b want %b%b", c, m0_resp, m1_resp, exp_r0, exp_r1);
      end
      if (exp_r0 || exp_r1) begin
        n_cmp++; if ((exp_r1 ? m1_rdata : m0_rdata) !== dat_q[0]) begin
          n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, exp_r1 ? m1_rdata : m0_rdata, dat_q[0]);
        end
      end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want 0", c, err); end
      if (s_resp && own_q.size() > 0) begin
        void'(own_q.pop_front());
        void'(dat_q.pop_front());
      end
      if (sreq && s_ack) begin
        last_g = g;
        if (!(g ? m1_we : m0_we)) begin
          own_q.push_back(g ? 1 : 0);
          dat_q.push_back(mem_val(g ? m1_addr : m0_addr));
        end
        if (g) busy1 = 0; else busy0 = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef RAM_ARB_PERF_CNT_EN
  task automatic test_perf_cnt();
    do_reset();
    m0_req = 1; m0_we = 1; s_ack = 1;
    repeat (10) tick();
    m0_req = 0; m1_req = 1; m1_we = 1;
    repeat (7) tick();
    m1_req = 0; m0_req = 1; s_ack = 0;
    repeat (3) tick();
    idle_inputs();
    tick();
    n_cmp++; if (m0_gcnt !== 32'd10) begin n_err++; $display("FAIL perf_m0: got %0d want 10", m0_gcnt); end
    n_cmp++; if (m1_gcnt !== 32'd7) begin n_err++; $display("FAIL perf_m1: got %0d want 7", m1_gcnt); end
    n_cmp++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL perf_stall: got %0d want 3", stall_cnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    tick();
    test_reset();
    test_alternate();
    test_stall();
    test_full();
    test_err();
    test_stale();
    test_random(400);
`ifdef RAM_ARB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
